// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch state encoding for the fetch stage
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'b00,
        FS_FETCH = 2'b01,
        FS_DRAIN = 2'b10,
        FS_HOLD  = 2'b11
    } fetch_state_t;

    // 32-bit modulo increment; wraps silently at the top of the address space
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory read port between fetch unit and memory
interface instr_fetch_if;

    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic        i_mem_busywait;
    logic [31:0] i_mem_readdata;

    modport master (
        output i_mem_read,
        output i_mem_address,
        input  i_mem_busywait,
        input  i_mem_readdata
    );

    modport slave (
        input  i_mem_read,
        input  i_mem_address,
        output i_mem_busywait,
        output i_mem_readdata
    );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - one-entry holding register for a word fetched during a stall
module fetch_buffer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_4,
    output logic [31:0] q_instr,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc_4,
    output logic        full
);

    // Clear wins over load so a redirect always empties the entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            q_instr <= 32'h0;
            q_pc    <= 32'h0;
            q_pc_4  <= 32'h0;
            full    <= 1'b0;
        end else if (clear) begin
            full    <= 1'b0;
        end else if (load) begin
            q_instr <= d_instr;
            q_pc    <= d_pc;
            q_pc_4  <= d_pc_4;
            full    <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with IF/ID register, stall buffer and redirect drain
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               branch_jump_signal,
    input  logic [31:0]        branch_jump_addr,
    input  logic               stall,
    instr_fetch_if.master      imem,
    output logic [31:0]        instr_out,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_4_out,
    output logic               valid_out
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  drain_addr, drain_addr_n;
    logic [31:0]  instr_n, pc_out_n, pc_4_n;
    logic         valid_n;
    logic         buf_load, buf_clear;
    logic [31:0]  buf_instr, buf_pc, buf_pc_4;
    logic         buf_full;
    logic         accept;
    logic [31:0]  target;

    assign accept = imem.i_mem_read && !imem.i_mem_busywait;
    assign target = branch_jump_addr & WORD_ALIGN_MASK;

    fetch_buffer u_fetch_buffer (
        .clk     (clk),
        .reset   (reset),
        .load    (buf_load),
        .clear   (buf_clear),
        .d_instr (imem.i_mem_readdata),
        .d_pc    (pc),
        .d_pc_4  (pc_plus4(pc)),
        .q_instr (buf_instr),
        .q_pc    (buf_pc),
        .q_pc_4  (buf_pc_4),
        .full    (buf_full)
    );

    // State, pc and IF/ID register update; reset dominates every other event
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= FS_IDLE;
            pc         <= RESET_PC;
            drain_addr <= 32'h0;
            instr_out  <= NOP;
            pc_out     <= 32'h0;
            pc_4_out   <= 32'h0;
            valid_out  <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_addr_n;
            instr_out  <= instr_n;
            pc_out     <= pc_out_n;
            pc_4_out   <= pc_4_n;
            valid_out  <= valid_n;
        end
    end

    // Next state, next pc and next IF/ID contents; redirect overrides stall
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        instr_n      = instr_out;
        pc_out_n     = pc_out;
        pc_4_n       = pc_4_out;
        valid_n      = valid_out;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        // A redirect always leaves a bubble in IF/ID and empties the buffer
        if (branch_jump_signal) begin
            instr_n   = NOP;
            pc_out_n  = 32'h0;
            pc_4_n    = 32'h0;
            valid_n   = 1'b0;
            buf_clear = 1'b1;
        end

        case (state)
            FS_IDLE: begin
                state_n = FS_FETCH;
                if (branch_jump_signal) begin
                    pc_n = target;
                end
            end
            FS_FETCH: begin
                if (branch_jump_signal) begin
                    pc_n = target;
                    if (!accept) begin
                        // Read still in flight: keep presenting the old address
                        drain_addr_n = pc;
                        state_n      = FS_DRAIN;
                    end
                end else if (accept && !stall) begin
                    instr_n  = imem.i_mem_readdata;
                    pc_out_n = pc;
                    pc_4_n   = pc_plus4(pc);
                    valid_n  = 1'b1;
                    pc_n     = pc_plus4(pc);
                end else if (accept) begin
                    buf_load = 1'b1;
                    state_n  = FS_HOLD;
                end else if (!stall) begin
                    // Downstream consumed the last word and nothing new arrived
                    instr_n  = NOP;
                    pc_out_n = 32'h0;
                    pc_4_n   = 32'h0;
                    valid_n  = 1'b0;
                end
            end
            FS_DRAIN: begin
                instr_n  = NOP;
                pc_out_n = 32'h0;
                pc_4_n   = 32'h0;
                valid_n  = 1'b0;
                if (branch_jump_signal) begin
                    pc_n = target;
                end
                if (accept) begin
                    state_n = FS_FETCH;
                end
            end
            FS_HOLD: begin
                if (branch_jump_signal) begin
                    pc_n    = target;
                    state_n = FS_FETCH;
                end else if (!stall) begin
                    instr_n   = buf_instr;
                    pc_out_n  = buf_pc;
                    pc_4_n    = buf_pc_4;
                    valid_n   = buf_full;
                    pc_n      = buf_pc_4;
                    buf_clear = 1'b1;
                    state_n   = FS_FETCH;
                end
            end
            default: begin
                state_n = FS_IDLE;
            end
        endcase
    end

    // Memory request decoded from state; drain keeps the abandoned address stable
    always_comb begin
        imem.i_mem_read    = (state == FS_FETCH) || (state == FS_DRAIN);
        imem.i_mem_address = ((state == FS_DRAIN) ? drain_addr : pc) & WORD_ALIGN_MASK;
    end

endmodule
